// File: rtl/sdpb_line_reader.sv
// sdpb_line_reader: read-side controller for a simple-dual-port line RAM.
//
// A start pulse reads i_length consecutive words from i_base_addr, wrapping modulo
// 2^ADDR_W. The words leave as a valid/ready stream with a last-word marker and a
// one-cycle done pulse. A small credit-controlled FIFO absorbs the RAM read latency,
// so downstream backpressure never loses a word.
//
// Ports:
//   i_clk, i_reset        clock (also the RAM clkb) and synchronous active-high reset
//   i_start               one-cycle line request, honoured only in IDLE
//   i_base_addr           first word address, sampled on an accepted start
//   i_length              word count (0 = empty line, clamped to 2^ADDR_W)
//   o_busy, o_done        busy outside IDLE; done is a one-cycle completion pulse
//   o_ram_ceb, o_ram_oce  RAM port-B clock enable and output-register enable
//   o_ram_adb, i_ram_dout RAM port-B address and read data
//   o_m_valid, i_m_ready  output stream handshake
//   o_m_data, o_m_last    stream word and final-word marker

module sdpb_line_reader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ram_ceb,
  output logic              o_ram_oce,
  output logic [ADDR_W-1:0] o_ram_adb,
  input  logic [DATA_W-1:0] i_ram_dout,
  output logic              o_m_valid,
  input  logic              i_m_ready,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  // Wide enough to hold fifo occupancy plus in-flight reads without overflow.
  localparam int unsigned CNT_W = PTR_W + 2;

  localparam logic [ADDR_W:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic [1:0]          r_state, w_state_d;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_issued;
  logic [RD_LAT-1:0]   r_pipe_v;
  logic [RD_LAT-1:0]   r_pipe_last;
  logic [DATA_W:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_start_ok;
  logic [ADDR_W:0]     w_len_clamp;
  logic [ADDR_W:0]     w_issued_inc;
  logic [CNT_W-1:0]    w_inflight;
  logic [CNT_W-1:0]    w_occ;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_push;
  logic                w_push_last;
  logic                w_valid;
  logic                w_pop;
  logic [DATA_W:0]     w_head;

  assign w_start_ok   = (r_state == S_IDLE) && i_start;
  assign w_len_clamp  = (i_length > MAX_LEN) ? MAX_LEN : i_length;
  assign w_issued_inc = r_issued + (ADDR_W + 1)'(1);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CNT_W'(r_pipe_v[i]);
    end
  end

  // Credit: every in-flight read already owns a FIFO slot.
  assign w_occ        = r_count + w_inflight;
  assign w_issue      = (r_state == S_RUN) && (r_issued < r_len) && (w_occ < DEPTH_C);
  assign w_issue_last = w_issue && (w_issued_inc == r_len);

  assign w_push      = r_pipe_v[RD_LAT-1];
  assign w_push_last = r_pipe_last[RD_LAT-1];
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid && i_m_ready;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_d = (w_len_clamp == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_issue_last) begin
          w_state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((w_inflight == '0) && (r_count == '0)) begin
          w_state_d = S_DONE;
        end
      end
      S_DONE:  w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_pipe_v    <= '0;
      r_pipe_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start_ok) begin
        r_base   <= i_base_addr;
        r_len    <= w_len_clamp;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= w_issued_inc;
      end

      // Return-path tracker: one stage per cycle of RAM latency.
      r_pipe_v[0]    <= w_issue;
      r_pipe_last[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_v[i]    <= r_pipe_v[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_mem[r_wr_ptr] <= {w_push_last, i_ram_dout};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_ram_ceb = w_issue;
  assign o_ram_oce = (RD_LAT == 2) ? 1'b1 : 1'b0;
  assign o_ram_adb = r_base + r_issued[ADDR_W-1:0];
  assign o_m_valid = w_valid;
  // Head is gated so an empty FIFO presents zeros rather than stale storage.
  assign o_m_data  = w_valid ? w_head[DATA_W-1:0] : '0;
  assign o_m_last  = w_valid && w_head[DATA_W];

endmodule

// File: tb/tb_sdpb_line_reader.sv
// tb_sdpb_line_reader: directed bench for sdpb_line_reader.
// Instance 0 uses RD_LAT=1 and instance 1 uses RD_LAT=2; both share stimulus and each
// has its own behavioural RAM preloaded with mem[i] = i.

module tb_sdpb_line_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic        m_ready;

  logic [1:0]       busy, done, ceb, oce, valid, last;
  logic [1:0][9:0]  adb;
  logic [1:0][15:0] data;
  logic [15:0]      rd0, rd1a, rd1b;
  logic [15:0]      mem [1024];

  int checks = 0;
  int errors = 0;

  sdpb_line_reader #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) u_dut0 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base), .i_length(len),
    .o_busy(busy[0]), .o_done(done[0]), .o_ram_ceb(ceb[0]), .o_ram_oce(oce[0]),
    .o_ram_adb(adb[0]), .i_ram_dout(rd0), .o_m_valid(valid[0]), .i_m_ready(m_ready),
    .o_m_data(data[0]), .o_m_last(last[0])
  );

  sdpb_line_reader #(.ADDR_W(10), .DATA_W(16), .RD_LAT(2), .FIFO_DEPTH(4)) u_dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base), .i_length(len),
    .o_busy(busy[1]), .o_done(done[1]), .o_ram_ceb(ceb[1]), .o_ram_oce(oce[1]),
    .o_ram_adb(adb[1]), .i_ram_dout(rd1b), .o_m_valid(valid[1]), .i_m_ready(m_ready),
    .o_m_data(data[1]), .o_m_last(last[1])
  );

  // Bypass-mode RAM: data valid the cycle after the address edge.
  always_ff @(posedge clk) begin
    if (ceb[0]) rd0 <= mem[adb[0]];
  end

  // Pipeline-mode RAM: extra output register gated by oce.
  always_ff @(posedge clk) begin
    if (ceb[1]) rd1a <= mem[adb[1]];
    if (oce[1]) rd1b <= rd1a;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int dut;        // which instance is checked
    int base;
    int len;
    int mode;       // 0: m_ready always 1, 1: pattern 1,0,0,1
    int restart_at; // sample index for an extra start pulse, -1 for none
    int exp_words;
    int exp_first;
    int exp_last;
    int exp_lat;    // edges from the accepting edge to the first visible m_valid
  } vec_t;

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy != 2'b00; i++) begin
      @(posedge clk); #1;
    end
    if (busy != 2'b00) check("idle_wait", int'(busy), 0);
  endtask

  task automatic run_line(input vec_t v);
    int d = v.dut;
    int npop = 0, niss = 0, ndone = 0;
    int k_done = -1, k_lastpop = -1, k_first = -1;
    int seq_err = 0, last_err = 0, stab_err = 0, occ_err = 0, adr_err = 0;
    int first_word = -1, last_word = -1, busy1 = -1, busy_after = -1;
    logic prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic prev_last = 1'b0;
    logic vv, ll;
    logic [15:0] dd;
    int idx;

    wait_idle();
    base = v.base[9:0];
    len = v.len[10:0];
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      idx = (k - 1) % 4;
      m_ready = (v.mode == 0) ? 1'b1 : ((idx == 0) || (idx == 3));
      if (k == v.restart_at) begin
        start = 1'b1;
        base = 10'd0;
        len = 11'd2;
      end else begin
        start = 1'b0;
      end
      vv = valid[d];
      dd = data[d];
      ll = last[d];
      if (k == 1) busy1 = int'(busy[d]);
      if (k_done > 0 && k == k_done + 1) busy_after = int'(busy[d]);
      if (prev_stall && (!vv || dd !== prev_data || ll !== prev_last)) stab_err++;
      if (ceb[d]) begin
        if (int'(adb[d]) != (v.base + niss) % 1024) adr_err++;
        niss++;
      end
      if (vv && k_first < 0) k_first = k;
      if (vv && m_ready) begin
        if (int'(dd) != (v.base + npop) % 1024) seq_err++;
        if (ll != (npop == v.exp_words - 1)) last_err++;
        if (ll) k_lastpop = k;
        if (npop == 0) first_word = int'(dd);
        last_word = int'(dd);
        npop++;
      end
      if (niss - npop > 4) occ_err++;
      if (done[d]) begin
        ndone++;
        if (k_done < 0) k_done = k;
      end
      prev_stall = vv && !m_ready;
      prev_data = dd;
      prev_last = ll;
      if (k_done > 0 && k == k_done + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;

    if (k_done < 0) check("done_timeout", k_done, 1);
    check("word_count", npop, v.exp_words);
    check("issue_count", niss, v.exp_words);
    check("data_order_errs", seq_err, 0);
    check("last_flag_errs", last_err, 0);
    check("stall_stability_errs", stab_err, 0);
    check("occupancy_errs", occ_err, 0);
    check("adb_sequence_errs", adr_err, 0);
    check("done_pulses", ndone, 1);
    check("busy_after_start", busy1, 1);
    check("busy_after_done", busy_after, 0);
    if (v.exp_words > 0) begin
      check("first_word", first_word, v.exp_first);
      check("last_word", last_word, v.exp_last);
      check("done_after_last_pop_ok", int'((k_done - k_lastpop >= 1) && (k_done - k_lastpop <= 2)), 1);
      if (v.mode == 0) begin
        check("first_valid_latency", k_first - 1, v.exp_lat);
        check("full_rate_span", k_lastpop - k_first, v.exp_words - 1);
      end
    end else begin
      check("empty_line_no_valid", k_first, -1);
      check("empty_line_done_time", k_done, 1);
    end
  endtask

  vec_t vecs[7];
  vec_t post;

  initial begin
    int pops;
    int nd;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    reset = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    m_ready = 1'b0;

    //        dut base  len   mode rst  words first last lat
    vecs[0] = '{0, 10,   5,    0, -1,  5,    10,   14,  2};
    vecs[1] = '{0, 1022, 4,    0, -1,  4,    1022, 1,   2};
    vecs[2] = '{0, 100,  16,   1, -1,  16,   100,  115, 2};
    vecs[3] = '{0, 7,    0,    0, -1,  0,    0,    0,   2};
    vecs[4] = '{0, 500,  1,    0, -1,  1,    500,  500, 2};
    vecs[5] = '{0, 3,    1200, 0, -1,  1024, 3,    2,   2};
    vecs[6] = '{1, 200,  32,   0, 3,   32,   200,  231, 3};

    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ceb", int'(ceb), 0);
    check("rst_adb0", int'(adb[0]), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_last", int'(last), 0);
    check("rst_data0", int'(data[0]), 0);
    check("oce_bypass", int'(oce[0]), 0);
    check("oce_pipeline", int'(oce[1]), 1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_line(vecs[i]);

    // Abort a line after three accepted words.
    wait_idle();
    base = 10'd300;
    len = 11'd8;
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pops = 0;
    for (int k = 0; k < 40 && pops < 3; k++) begin
      if (valid[0] && m_ready) pops++;
      if (pops < 3) begin
        @(posedge clk); #1;
      end
    end
    check("abort_pops_seen", pops, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", int'(valid), 0);
    check("abort_ceb", int'(ceb), 0);
    check("abort_busy", int'(busy), 0);
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (done != 2'b00 || valid != 2'b00) nd++;
      @(posedge clk); #1;
    end
    check("abort_no_done_or_valid", nd, 0);

    post = '{0, 0, 2, 0, -1, 2, 0, 1, 2};
    run_line(post);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
